// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and parity mode.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        PARITY_ODD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic                 par);
    return (^data ^ par) != PARITY_ODD;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (high).
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], din};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign dout = sync_q[1];

endmodule

// File: rtl/receiver.sv
// UART receiver: start, 8 data bits LSB first, odd parity, stop. Reports parity
// and framing errors with each frame; a held-low line after stop parks in BREAK.
module receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRx,
  output logic [7:0] odata,
  output logic       oValid,
  output logic       oParityErr,
  output logic       oFrameErr,
  output logic       oBusy
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rxs;

  rx_sync u_rx_sync (
    .clk  (iClk),
    .rst  (iRst),
    .din  (iRx),
    .dout (rxs)
  );

  rx_state_e              state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = perr_q;
    ferr_d   = ferr_q;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d         = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == IDX_LAST) state_d = ST_PARITY;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d   = '0;
          parity_d = rxs;
          state_d  = ST_STOP;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          data_d  = shift_q;
          valid_d = 1'b1;
          perr_d  = parity_error(shift_q, parity_q);
          ferr_d  = !rxs;
          state_d = rxs ? ST_IDLE : ST_BREAK;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_BREAK: begin
        tick_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign odata      = data_q;
  assign oValid     = valid_q;
  assign oParityErr = perr_q;
  assign oFrameErr  = ferr_q;
  assign oBusy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed scenarios plus random frames,
// checked against a frame-level reference model (popcount parity, queue of frames).
module tb_receiver;

  localparam int unsigned CPB = 16;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iRx  = 1'b1;
  logic [7:0] odata;
  logic       oValid, oParityErr, oFrameErr, oBusy;

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iRx        (iRx),
    .odata      (odata),
    .oValid     (oValid),
    .oParityErr (oParityErr),
    .oFrameErr  (oFrameErr),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] hold_data = '0;
  logic       hold_perr = 1'b0;
  logic       hold_ferr = 1'b0;
  bit         mon_en    = 1'b0;

  // Reference: a frame is accepted when the set bits of data plus parity bit count odd.
  function automatic frame_t model_frame(input logic [7:0] d, input logic par, input logic stop);
    frame_t f;
    f.data = d;
    f.perr = ((($countones(d) + int'(par)) % 2) == 0);
    f.ferr = !stop;
    return f;
  endfunction

  function automatic logic good_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  always @(negedge iClk) begin
    if (mon_en) begin
      if (oValid && exp_q.size() == 0) begin
        check("spurious_valid", oValid, 1'b0);
      end else if (oValid) begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_data", odata, e.data);
        check("frame_perr", oParityErr, e.perr);
        check("frame_ferr", oFrameErr, e.ferr);
        hold_data = e.data;
        hold_perr = e.perr;
        hold_ferr = e.ferr;
      end else begin
        check("held_outputs", {odata, oParityErr, oFrameErr}, {hold_data, hold_perr, hold_ferr});
      end
    end
  end

  task automatic idle(input int unsigned n);
    iRx = 1'b1;
    repeat (n) @(negedge iClk);
  endtask

  task automatic send_bit(input logic b);
    iRx = b;
    repeat (CPB) @(negedge iClk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_q.push_back(model_frame(d, par, stop));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic drain(input string tag);
    int unsigned cnt = 0;
    while (exp_q.size() != 0 && cnt < 400) begin
      @(negedge iClk);
      cnt++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_odata"}, odata, 8'h00);
    check({tag, "_valid"}, oValid, 1'b0);
    check({tag, "_perr"},  oParityErr, 1'b0);
    check({tag, "_ferr"},  oFrameErr, 1'b0);
    check({tag, "_busy"},  oBusy, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy;
    logic [7:0] d;
    logic par, stop;

    repeat (3) @(posedge iClk);
    #1;
    check_reset_outputs("reset");
    @(negedge iClk);
    iRst   = 1'b0;
    mon_en = 1'b1;
    idle(10);

    // Clean frame
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(5);
    drain("a5_done");

    // Wrong parity
    send_frame(8'h01, 1'b1, 1'b1);
    idle(5);
    drain("01_done");

    // Short glitch on the line is rejected
    saw_busy = 1'b0;
    iRx = 1'b0;
    repeat (4) begin
      @(negedge iClk);
      if (oBusy) saw_busy = 1'b1;
    end
    iRx = 1'b1;
    for (int k = 0; k < 8 && oBusy; k++) begin
      @(posedge iClk);
      #1;
      if (oBusy) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", saw_busy, 1'b1);
    check("glitch_busy_fall", oBusy, 1'b0);
    idle(20);

    // Stop bit low, line held low: BREAK until the line returns high
    send_frame(8'h3C, good_parity(8'h3C), 1'b0);
    iRx = 1'b0;
    repeat (24) begin
      @(negedge iClk);
      check("break_busy", oBusy, 1'b1);
    end
    iRx = 1'b1;
    repeat (4) @(negedge iClk);
    check("break_exit", oBusy, 1'b0);
    drain("3c_done");
    idle(10);
    send_frame(8'h55, good_parity(8'h55), 1'b1);
    idle(5);
    drain("55_done");

    // Back-to-back frames
    send_frame(8'h00, good_parity(8'h00), 1'b1);
    send_frame(8'hFF, good_parity(8'hFF), 1'b1);
    send_frame(8'h81, good_parity(8'h81), 1'b1);
    idle(5);
    drain("b2b_done");

    // Reset during data bit 4 of 0x77
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h77 >> i));
    iRx = 1'b1;
    repeat (CPB / 2) @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    hold_data = '0;
    hold_perr = 1'b0;
    hold_ferr = 1'b0;
    check_reset_outputs("midrst");
    @(negedge iClk);
    iRst = 1'b0;
    idle(20);
    check("midrst_no_frame", exp_q.size(), 0);
    send_frame(8'h12, good_parity(8'h12), 1'b1);
    idle(5);
    drain("12_done");

    // Random frames with occasional parity and framing errors
    for (int n = 0; n < 25; n++) begin
      d    = 8'($urandom);
      par  = good_parity(d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, par, stop);
      if (!stop) begin
        iRx = 1'b0;
        repeat ($urandom_range(0, 20)) @(negedge iClk);
        idle(4);
      end
      idle($urandom_range(0, 30));
    end
    idle(5);
    drain("random_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
